// File: rtl/no_break_pkg.sv
// Shared types for the no-break mains path: qualifier FSM states and default widths.
package no_break_pkg;

  typedef enum logic [2:0] {
    SEM_ENERGIA,
    CONFIRMA_ON,
    COM_ENERGIA,
    CONFIRMA_OFF,
    BLOQUEIO
  } estado_rede_t;

  localparam int NF_BITS_DEF = 4;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser bringing a single asynchronous level into the clk domain.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qualificador_rede.sv
// Mains-present qualifier: synchronises and debounces the raw input, counts failures
// and locks out a supply that fails too often inside the observation window.
module qualificador_rede
  import no_break_pkg::*;
#(
  parameter int DEB_ON     = 4,
  parameter int DEB_OFF    = 2,
  parameter int JANELA     = 16,
  parameter int MAX_FALHAS = 3,
  parameter int HOLDOFF    = 8,
  parameter int NF_BITS    = NF_BITS_DEF
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic               tomada_bruta,
  input  logic               limpa_falhas,
  output logic               energia_tomada,
  output logic               falha_pulso,
  output logic               retorno_pulso,
  output logic               instavel,
  output logic [NF_BITS-1:0] num_falhas
);

  localparam int CNT_MAX = (HOLDOFF > DEB_ON) ? HOLDOFF : DEB_ON;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WIN_W   = (JANELA > 1) ? $clog2(JANELA) : 1;
  localparam int FJ_W    = $clog2(MAX_FALHAS + 1);

  function automatic logic [NF_BITS-1:0] sat_inc(input logic [NF_BITS-1:0] v);
    return (&v) ? v : v + NF_BITS'(1);
  endfunction

  logic tomada_s;

  sincronizador_2ff u_sync (
    .clk (clk_2),
    .rst (reset),
    .d   (tomada_bruta),
    .q   (tomada_s)
  );

  estado_rede_t       estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [FJ_W-1:0]    fj_q, fj_d;
  logic [NF_BITS-1:0] num_q, num_d;
  logic               energia_q, energia_d;
  logic               falha_q, falha_d;
  logic               retorno_q, retorno_d;
  logic               instavel_q, instavel_d;

  logic               wrap;
  logic               fail_ev;
  logic [FJ_W-1:0]    fj_base;
  logic [FJ_W-1:0]    fj_inc;

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    fj_d       = fj_q;
    num_d      = num_q;
    energia_d  = energia_q;
    falha_d    = 1'b0;
    retorno_d  = 1'b0;
    instavel_d = instavel_q;
    fail_ev    = 1'b0;

    // The flicker window is frozen while locked out.
    wrap = (estado_q != BLOQUEIO) && (win_q == WIN_W'(JANELA - 1));
    if (estado_q != BLOQUEIO) begin
      win_d = wrap ? '0 : win_q + WIN_W'(1);
      if (wrap) fj_d = '0;
    end
    fj_base = wrap ? '0 : fj_q;
    fj_inc  = fj_base + FJ_W'(1);

    case (estado_q)
      SEM_ENERGIA: begin
        energia_d = 1'b0;
        if (tomada_s) begin
          estado_d = CONFIRMA_ON;
          cnt_d    = CNT_W'(1);
        end
      end
      CONFIRMA_ON: begin
        if (!tomada_s) begin
          estado_d = SEM_ENERGIA;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(DEB_ON - 1)) begin
          estado_d  = COM_ENERGIA;
          energia_d = 1'b1;
          retorno_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COM_ENERGIA: begin
        energia_d = 1'b1;
        if (!tomada_s) begin
          estado_d = CONFIRMA_OFF;
          cnt_d    = CNT_W'(1);
        end
      end
      CONFIRMA_OFF: begin
        if (tomada_s) begin
          estado_d = COM_ENERGIA;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(DEB_OFF - 1)) begin
          falha_d   = 1'b1;
          energia_d = 1'b0;
          fail_ev   = 1'b1;
          fj_d      = fj_inc;
          cnt_d     = '0;
          if (fj_inc >= FJ_W'(MAX_FALHAS)) begin
            estado_d   = BLOQUEIO;
            instavel_d = 1'b1;
          end else begin
            estado_d = SEM_ENERGIA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLOQUEIO: begin
        energia_d = 1'b0;
        if (!tomada_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          estado_d   = COM_ENERGIA;
          energia_d  = 1'b1;
          retorno_d  = 1'b1;
          instavel_d = 1'b0;
          fj_d       = '0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        estado_d   = SEM_ENERGIA;
        cnt_d      = '0;
        energia_d  = 1'b0;
        instavel_d = 1'b0;
      end
    endcase

    // A clear on the same edge as a failure wins.
    if (limpa_falhas) num_d = '0;
    else if (fail_ev) num_d = sat_inc(num_q);
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      estado_q   <= SEM_ENERGIA;
      cnt_q      <= '0;
      win_q      <= '0;
      fj_q       <= '0;
      num_q      <= '0;
      energia_q  <= 1'b0;
      falha_q    <= 1'b0;
      retorno_q  <= 1'b0;
      instavel_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      fj_q       <= fj_d;
      num_q      <= num_d;
      energia_q  <= energia_d;
      falha_q    <= falha_d;
      retorno_q  <= retorno_d;
      instavel_q <= instavel_d;
    end
  end

  assign energia_tomada = energia_q;
  assign falha_pulso    = falha_q;
  assign retorno_pulso  = retorno_q;
  assign instavel       = instavel_q;
  assign num_falhas     = num_q;

endmodule

// File: tb/tb_qualificador_rede.sv
// Bench for qualificador_rede: directed scenarios plus random stimulus against a run-length model.
module tb_qualificador_rede;

  localparam int DEB_ON     = 4;
  localparam int DEB_OFF    = 2;
  localparam int JANELA     = 16;
  localparam int MAX_FALHAS = 3;
  localparam int HOLDOFF    = 8;
  localparam int NF_BITS    = 4;
  localparam int NF_MAX     = (1 << NF_BITS) - 1;

  logic               clk_2 = 1'b0;
  logic               reset = 1'b1;
  logic               tomada_bruta = 1'b0;
  logic               limpa_falhas = 1'b0;
  logic               energia_tomada;
  logic               falha_pulso;
  logic               retorno_pulso;
  logic               instavel;
  logic [NF_BITS-1:0] num_falhas;

  int errors = 0;
  int checks = 0;

  always #5 clk_2 = ~clk_2;

  qualificador_rede #(
    .DEB_ON(DEB_ON), .DEB_OFF(DEB_OFF), .JANELA(JANELA),
    .MAX_FALHAS(MAX_FALHAS), .HOLDOFF(HOLDOFF), .NF_BITS(NF_BITS)
  ) dut (
    .clk_2          (clk_2),
    .reset          (reset),
    .tomada_bruta   (tomada_bruta),
    .limpa_falhas   (limpa_falhas),
    .energia_tomada (energia_tomada),
    .falha_pulso    (falha_pulso),
    .retorno_pulso  (retorno_pulso),
    .instavel       (instavel),
    .num_falhas     (num_falhas)
  );

  // Reference model: the qualified level follows run lengths of the synchronised input;
  // failures are tagged with the index of the window they fall in.
  bit m_s, m_s1, m_level, m_locked, m_fail, m_ret;
  int m_run_hi, m_run_lo, m_num, m_active;
  int m_fq[$];

  function automatic void model_reset();
    m_s = 0; m_s1 = 0; m_level = 0; m_locked = 0; m_fail = 0; m_ret = 0;
    m_run_hi = 0; m_run_lo = 0; m_num = 0; m_active = 0;
    m_fq.delete();
  endfunction

  function automatic void model_step(input bit raw, input bit limpa);
    bit s, was_locked;
    int idx, n;
    s = m_s; m_s = m_s1; m_s1 = raw;
    if (s) begin m_run_hi++; m_run_lo = 0; end
    else   begin m_run_lo++; m_run_hi = 0; end
    m_fail = 0; m_ret = 0;
    was_locked = m_locked;
    idx = (m_active + 1) / JANELA;
    if (m_locked) begin
      if (m_run_hi == HOLDOFF) begin
        m_locked = 0; m_level = 1; m_ret = 1; m_fq.delete();
      end
    end else if (!m_level) begin
      if (m_run_hi == DEB_ON) begin m_level = 1; m_ret = 1; end
    end else if (m_run_lo == DEB_OFF) begin
      m_level = 0; m_fail = 1;
      m_fq.push_back(idx);
      n = 0;
      foreach (m_fq[i]) if (m_fq[i] == idx) n++;
      if (n >= MAX_FALHAS) m_locked = 1;
    end
    if (!was_locked) m_active++;
    if (limpa) m_num = 0;
    else if (m_fail && m_num < NF_MAX) m_num++;
  endfunction

  function automatic logic [7:0] dut_vec();
    return {energia_tomada, falha_pulso, retorno_pulso, instavel, num_falhas};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_level, m_fail, m_ret, m_locked, 4'(m_num)};
  endfunction

  task automatic step(input bit raw, input bit limpa);
    tomada_bruta = raw;
    limpa_falhas = limpa;
    @(posedge clk_2);
    model_step(raw, limpa);
    #1;
  endtask

  task automatic do_reset();
    tomada_bruta = 1'b0;
    limpa_falhas = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tomada_bruta = 1'b1;
    repeat (3) @(posedge clk_2);
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_hold got=%h exp=00", dut_vec());
    end
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_release got=%h exp=00", dut_vec());
    end
  endtask

  task automatic test_power_on();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL power_on_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      checks++;
      if (energia_tomada !== (k >= 6) || retorno_pulso !== (k == 6)) begin
        errors++;
        $display("FAIL power_on_edge edge=%0d got=%b%b exp=%b%b", k, energia_tomada, retorno_pulso,
                 k >= 6, k == 6);
      end
    end
    checks++;
    if (num_falhas !== 4'd0) begin
      errors++; $display("FAIL power_on_count got=%0d exp=0", num_falhas);
    end
  endtask

  task automatic test_glitch();
    bit raw_seq[$];
    int pulses, low_seen;
    raw_seq = {0, 1, 1, 1, 1, 1, 1};
    pulses = 0; low_seen = 0;
    foreach (raw_seq[i]) begin
      step(raw_seq[i], 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL glitch_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (falha_pulso) pulses++;
      if (!energia_tomada) low_seen++;
    end
    checks++;
    if (pulses != 0 || low_seen != 0) begin
      errors++; $display("FAIL glitch_absorbed pulses=%0d low=%0d exp=0,0", pulses, low_seen);
    end
    raw_seq = {0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    pulses = 0;
    foreach (raw_seq[i]) begin
      step(raw_seq[i], 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL drop_model i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (falha_pulso) pulses++;
    end
    checks++;
    if (pulses != 1 || num_falhas !== 4'd1 || energia_tomada !== 1'b1) begin
      errors++;
      $display("FAIL drop_failure pulses=%0d num=%0d en=%b exp=1,1,1", pulses, num_falhas, energia_tomada);
    end
  endtask

  task automatic test_lockout();
    bit pat[$];
    int edge_n;
    pat = {0, 0, 1, 1, 1, 1};
    do_reset();
    edge_n = 0;
    for (int k = 0; k < 13 + 3 * 6; k++) begin
      step((k < 13) ? 1'b1 : pat[(k - 13) % 6], 0);
      edge_n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lockout_model edge=%0d got=%h exp=%h", edge_n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (instavel !== 1'b1 || energia_tomada !== 1'b0) begin
      errors++; $display("FAIL lockout_enter inst=%b en=%b exp=1,0", instavel, energia_tomada);
    end
    for (int k = 0; k < 3 + 1 + 2; k++) begin
      step((k == 3) ? 1'b0 : 1'b1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL holdoff_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (instavel !== 1'b1 || energia_tomada !== 1'b0) begin
      errors++; $display("FAIL holdoff_short inst=%b en=%b exp=1,0", instavel, energia_tomada);
    end
    for (int k = 0; k < HOLDOFF; k++) begin
      step(1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL holdoff_exit_model k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (instavel !== 1'b0 || energia_tomada !== 1'b1 || retorno_pulso !== 1'b1) begin
      errors++;
      $display("FAIL holdoff_exit inst=%b en=%b ret=%b exp=0,1,1", instavel, energia_tomada, retorno_pulso);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (6) step(1, 0);
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 22; k++) begin
        step((k < 2) ? 1'b0 : 1'b1, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL sat_model f=%0d k=%0d got=%h exp=%h", f, k, dut_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (num_falhas !== 4'd15 || instavel !== 1'b0) begin
      errors++; $display("FAIL sat_value num=%0d inst=%b exp=15,0", num_falhas, instavel);
    end
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(1, 1);
    checks++;
    if (falha_pulso !== 1'b1 || num_falhas !== 4'd0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL clear_beats_inc pulse=%b num=%0d exp=1,0", falha_pulso, num_falhas);
    end
    repeat (6) step(1, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL clear_after got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    repeat (4) step(1, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_confirma got=%h exp=00", dut_vec());
    end
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1, 0);
      checks++;
      if (energia_tomada !== (k == 6) || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_rearm edge=%0d en=%b exp=%b", k, energia_tomada, k == 6);
      end
    end
  endtask

  task automatic test_wrap_failure();
    bit pat[$];
    pat = {0, 0, 1, 1, 1, 1};
    do_reset();
    for (int e = 1; e <= 12 + 3 * 6; e++) begin
      step((e <= 12) ? 1'b1 : pat[(e - 13) % 6], 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_model edge=%0d got=%h exp=%h", e, dut_vec(), exp_vec());
      end
      if (e == 16 || e == 22) begin
        checks++;
        if (falha_pulso !== 1'b1 || instavel !== 1'b0) begin
          errors++; $display("FAIL wrap_fail edge=%0d pulse=%b inst=%b exp=1,0", e, falha_pulso, instavel);
        end
      end
      if (e == 28) begin
        checks++;
        if (falha_pulso !== 1'b1 || instavel !== 1'b1) begin
          errors++; $display("FAIL wrap_lock edge=%0d pulse=%b inst=%b exp=1,1", e, falha_pulso, instavel);
        end
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    checks++;
    if (instavel !== 1'b1) begin
      errors++; $display("FAIL lock_before_reset inst=%b exp=1", instavel);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 8'h00) begin
      errors++; $display("FAIL reset_lock got=%h exp=00", dut_vec());
    end
    @(negedge clk_2);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lock_rearm edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    do_reset();
    for (int r = 0; r < 250; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        step(lvl, ($urandom_range(0, 39) == 0));
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_model r=%0d k=%0d got=%h exp=%h", r, k, dut_vec(), exp_vec());
        end
        checks++;
        if (falha_pulso && retorno_pulso) begin
          errors++; $display("FAIL random_overlap r=%0d got=11 exp=not both", r);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_on();
    test_glitch();
    test_lockout();
    test_saturation();
    test_reset_mid_debounce();
    test_wrap_failure();
    test_reset_mid_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
